multicycle_control_112: RTL and testbench
=========================================

// Module: multicycle_control_112
// PURPOSE
//  Multicycle MIPS controller: FSM that sequences the shared datapath (one ALU, one memory
//  port, register file) through IF/ID/EXE/MEM/WB for each instruction. Issues per-state enables,
//  mux selects and ALU function codes. Waits on a memory-ready handshake and counts retired
//  instructions. Replaces the single-cycle decode in the multicycle CPU top.
// PARAMETERS
//  CNT_W    16   width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  op        in   6      IR[31:26], stable from ID until the next IF
//  func      in   6      IR[5:0]
//  zero      in   1      ALU zero flag (valid in EXE)
//  mem_ready in   1      memory access completes this cycle
//  PCWr      out  1      PC write enable
//  NPCop     out  2      next-PC select: 00 PC+4, 01 branch (PC+4+sext(imm)<<2), 10 jump
//  IRWr      out  1      instruction register write enable
//  RegDst    out  1      1 = rd, 0 = rt
//  ALUsrc    out  1      1 = extended immediate, 0 = rt data
//  ALUctr    out  3      000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sltu
//  ExtOp     out  1      1 = sign-extend, 0 = zero-extend
//  MemtoReg  out  1      1 = write-back from memory data register
//  RegWr     out  1      register file write enable
//  MemWr     out  1      data memory write enable
//  MemRd     out  1      memory read request (IF fetch or lw)
//  state     out  3      current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
//  illegal   out  1      sticky: an unsupported op/func was decoded
//  instr_cnt out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Supported: R-type op=000000 with func addu 100001, subu 100011, and 100100, or 100101,
//   slt 101010, sltu 101011; ori 001101; addiu 001001; lw 100011; sw 101011; beq 000100; j 000010.
//  Reset (async): state=IF, illegal=0, instr_cnt=0. While rst=1, PCWr/IRWr/RegWr/MemWr/MemRd=0.
//  Outputs decode from the registered state plus op/func/zero/mem_ready. Every output not
//   listed for a state is 0; ALUctr defaults to 000 (add).
//  IF:  MemRd=1. If mem_ready: IRWr=1, PCWr=1, NPCop=00, go to ID; else hold IF with no writes.
//  ID:  j: PCWr=1, NPCop=10, retire, go to IF. Illegal op/func: set illegal, retire nothing,
//       go to IF (NOP). Otherwise go to EXE.
//  EXE: R-type: ALUsrc=0, ALUctr from func, go to WB. ori: ALUsrc=1, ExtOp=0, ALUctr=011, go to WB.
//       addiu: ALUsrc=1, ExtOp=1, ALUctr=000, go to WB. lw/sw: ALUsrc=1, ExtOp=1, ALUctr=000,
//       go to MEM. beq: ALUsrc=0, ALUctr=001, PCWr=zero, NPCop=01, retire, go to IF.
//  MEM: sw: MemWr=1 each cycle until mem_ready; on mem_ready retire and go to IF.
//       lw: MemRd=1 until mem_ready, then go to WB. No state change while mem_ready=0.
//  WB:  RegWr=1. RegDst=1 for R-type, else 0. MemtoReg=1 for lw, else 0. Retire, go to IF.
//  Retire = instr_cnt+1 on that clock edge; wraps from all-ones to 0.
//  Cycle counts with mem_ready=1: j 2, beq 3, sw 4, R/ori/addiu 4, lw 5.
//  Unused state encodings 5-7 return to IF on the next edge with all enables 0.
//  rst mid-instruction: state returns to IF immediately and no write enable reaches
//   the next edge. illegal is cleared only by rst.
// TESTING
//  1 Reset, then addu (op 0, func 100001), mem_ready=1 -> states 0,1,2,4; RegWr=1 and
//    RegDst=1 in WB; ALUctr=000 in EXE; instr_cnt 0->1.
//  2 lw, mem_ready low for 3 MEM cycles -> stays in MEM (MemRd=1, RegWr=0); then WB with
//    MemtoReg=1; total 8 cycles.
//  3 beq with zero=1 -> PCWr=1, NPCop=01 in EXE. With zero=0 -> PCWr=0. Both: 3 cycles,
//    then back to IF.
//  4 sw -> MemWr=1 only in MEM; RegWr stays 0 throughout; j -> PCWr=1, NPCop=10 in ID,
//    2 cycles.
//  5 op=111111 -> illegal=1 after ID, instr_cnt unchanged, next state IF. Assert rst in
//    MEM of lw -> state=0, MemRd=0, illegal=0 asynchronously.
//  6 With CNT_W=4, retire 16 addiu -> instr_cnt wraps to 0; ori -> ExtOp=0, ALUctr=011.

Source files
------------

// File: rtl/multicycle_control_112_if.sv
// rtl/multicycle_control_112_if.sv - controller <-> datapath signal bundle for the multicycle MIPS controller
interface multicycle_control_112_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             PCWr;
  logic [1:0]       NPCop;
  logic             IRWr;
  logic             RegDst;
  logic             ALUsrc;
  logic [2:0]       ALUctr;
  logic             ExtOp;
  logic             MemtoReg;
  logic             RegWr;
  logic             MemWr;
  logic             MemRd;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, func, zero, mem_ready,
    output PCWr, NPCop, IRWr, RegDst, ALUsrc, ALUctr, ExtOp, MemtoReg,
           RegWr, MemWr, MemRd, state, illegal, instr_cnt
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  PCWr, NPCop, IRWr, RegDst, ALUsrc, ALUctr, ExtOp, MemtoReg,
           RegWr, MemWr, MemRd, state, illegal, instr_cnt
  );
endinterface

// File: rtl/multicycle_control_112.sv
// rtl/multicycle_control_112.sv - multicycle MIPS controller FSM (IF/ID/EXE/MEM/WB) with retire counter
module multicycle_control_112 #(
  parameter int CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_112_if.master bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;

  logic       is_r, is_ori, is_addiu, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0] r_aluctr;

  always_comb begin
    r_aluctr = 3'b000;
    is_r     = 1'b0;
    if (bus.op == OP_R) begin
      is_r = 1'b1;
      case (bus.func)
        6'b100001: r_aluctr = 3'b000;
        6'b100011: r_aluctr = 3'b001;
        6'b100100: r_aluctr = 3'b010;
        6'b100101: r_aluctr = 3'b011;
        6'b101010: r_aluctr = 3'b100;
        6'b101011: r_aluctr = 3'b101;
        default:   is_r     = 1'b0;
      endcase
    end
  end

  assign is_ori   = (bus.op == OP_ORI);
  assign is_addiu = (bus.op == OP_ADDIU);
  assign is_lw    = (bus.op == OP_LW);
  assign is_sw    = (bus.op == OP_SW);
  assign is_beq   = (bus.op == OP_BEQ);
  assign is_j     = (bus.op == OP_J);
  assign legal    = is_r | is_ori | is_addiu | is_lw | is_sw | is_beq | is_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IF;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IF: if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        if (is_j) begin
          state_d = S_IF;
          retire  = 1'b1;
        end else if (!legal) begin
          state_d   = S_IF;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_r || is_ori || is_addiu) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_IF;
          retire  = is_beq;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
            retire  = is_sw;
          end
        end
      end
      S_WB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

  always_comb begin
    bus.PCWr     = 1'b0;
    bus.NPCop    = 2'b00;
    bus.IRWr     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUsrc   = 1'b0;
    bus.ALUctr   = 3'b000;
    bus.ExtOp    = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWr    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.MemRd    = 1'b0;
    case (state_q)
      S_IF: begin
        bus.MemRd = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWr = 1'b1;
          bus.PCWr = 1'b1;
        end
      end
      S_ID: begin
        if (is_j) begin
          bus.PCWr  = 1'b1;
          bus.NPCop = 2'b10;
        end
      end
      S_EXE: begin
        if (is_r) begin
          bus.ALUctr = r_aluctr;
        end else if (is_ori) begin
          bus.ALUsrc = 1'b1;
          bus.ALUctr = 3'b011;
        end else if (is_addiu || is_lw || is_sw) begin
          bus.ALUsrc = 1'b1;
          bus.ExtOp  = 1'b1;
        end else if (is_beq) begin
          bus.ALUctr = 3'b001;
          bus.PCWr   = bus.zero;
          bus.NPCop  = 2'b01;
        end
      end
      S_MEM: begin
        bus.MemWr = is_sw;
        bus.MemRd = is_lw;
      end
      S_WB: begin
        bus.RegWr    = 1'b1;
        bus.RegDst   = is_r;
        bus.MemtoReg = is_lw;
      end
      default: ;
    endcase
    // Reset must silence every write/request even though state_q already reads IF.
    if (rst) begin
      bus.PCWr  = 1'b0;
      bus.IRWr  = 1'b0;
      bus.RegWr = 1'b0;
      bus.MemWr = 1'b0;
      bus.MemRd = 1'b0;
    end
  end

  assign bus.state     = state_q;
  assign bus.illegal   = illegal_q;
  assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_multicycle_control_112.sv
// tb/tb_multicycle_control_112.sv - scoreboard bench for multicycle_control_112 with a per-instruction trace model
module tb_multicycle_control_112;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] npc;
    logic       irwr;
    logic       regdst;
    logic       alusrc;
    logic [2:0] aluctr;
    logic       extop;
    logic       memtoreg;
    logic       regwr;
    logic       memwr;
    logic       memrd;
    logic       ill;
    logic [3:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mr;
    exp_t       e;
  } plan_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_112_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control_112 #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  plan_t plan[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  logic  go     = 1'b0;
  logic  [3:0] cnt_m = '0;
  logic  ill_m = 1'b0;

  function automatic exp_t sample();
    exp_t g;
    g.st = bus.state; g.pcwr = bus.PCWr; g.npc = bus.NPCop; g.irwr = bus.IRWr;
    g.regdst = bus.RegDst; g.alusrc = bus.ALUsrc; g.aluctr = bus.ALUctr;
    g.extop = bus.ExtOp; g.memtoreg = bus.MemtoReg; g.regwr = bus.RegWr;
    g.memwr = bus.MemWr; g.memrd = bus.MemRd; g.ill = bus.illegal; g.cnt = bus.instr_cnt;
    return g;
  endfunction

  task automatic check(string name, exp_t got, exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic emit(exp_t e, logic [5:0] op, logic [5:0] func, logic z, logic mr);
    plan_t p;
    e.ill = ill_m;
    e.cnt = cnt_m;
    p.op = op; p.func = func; p.zero = z; p.mr = mr; p.e = e;
    plan.push_back(p);
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction from the instruction table.
  task automatic gen(logic [5:0] op, logic [5:0] func, logic z, int wif, int wmem);
    exp_t e;
    int   k;
    logic r_ok, lw, sw;
    logic [2:0] rfn;
    r_ok = 1'b1;
    case (func)
      6'd33: rfn = 3'd0;
      6'd35: rfn = 3'd1;
      6'd36: rfn = 3'd2;
      6'd37: rfn = 3'd3;
      6'd42: rfn = 3'd4;
      6'd43: rfn = 3'd5;
      default: begin rfn = 3'd0; r_ok = 1'b0; end
    endcase
    r_ok = r_ok && (op == 6'd0);
    lw = (op == 6'b100011);
    sw = (op == 6'b101011);
    for (k = 0; k < wif; k++) begin
      e = '0; e.memrd = 1'b1;
      emit(e, op, func, z, 1'b0);
    end
    e = '0; e.memrd = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    emit(e, op, func, z, 1'b1);
    e = '0; e.st = 3'd1;
    if (op == 6'b000010) begin
      e.pcwr = 1'b1; e.npc = 2'b10;
      emit(e, op, func, z, 1'($urandom_range(0, 1)));
      cnt_m++;
      return;
    end
    emit(e, op, func, z, 1'($urandom_range(0, 1)));
    if (!(r_ok || lw || sw || op == 6'b001101 || op == 6'b001001 || op == 6'b000100)) begin
      ill_m = 1'b1;
      return;
    end
    e = '0; e.st = 3'd2;
    if (op == 6'b000100) begin
      e.aluctr = 3'd1; e.pcwr = z; e.npc = 2'b01;
      emit(e, op, func, z, 1'($urandom_range(0, 1)));
      cnt_m++;
      return;
    end
    if (r_ok) e.aluctr = rfn;
    else if (op == 6'b001101) begin e.alusrc = 1'b1; e.aluctr = 3'd3; end
    else begin e.alusrc = 1'b1; e.extop = 1'b1; end
    emit(e, op, func, z, 1'($urandom_range(0, 1)));
    if (lw || sw) begin
      e = '0; e.st = 3'd3; e.memwr = sw; e.memrd = lw;
      for (k = 0; k < wmem; k++) emit(e, op, func, z, 1'b0);
      emit(e, op, func, z, 1'b1);
      if (sw) begin cnt_m++; return; end
    end
    e = '0; e.st = 3'd4; e.regwr = 1'b1; e.regdst = r_ok; e.memtoreg = lw;
    emit(e, op, func, z, 1'($urandom_range(0, 1)));
    cnt_m++;
  endtask

  // Driver: issue one planned cycle and hand its expectation to the scoreboard.
  always @(posedge clk) begin
    if (go) begin
      #1;
      if (plan.size() > 0) begin
        plan_t p;
        p = plan.pop_front();
        bus.op = p.op; bus.func = p.func; bus.zero = p.zero; bus.mem_ready = p.mr;
        exp_q.push_back(p.e);
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t w;
      w = exp_q.pop_front();
      check($sformatf("cycle_%0d", cyc), sample(), w);
      cyc++;
    end
  end

  initial begin
    logic [5:0] ops [0:7];
    logic [5:0] fns [0:6];
    exp_t w;
    int   n;
    ops[0] = 6'b000000; ops[1] = 6'b001101; ops[2] = 6'b001001; ops[3] = 6'b100011;
    ops[4] = 6'b101011; ops[5] = 6'b000100; ops[6] = 6'b000010; ops[7] = 6'b111111;
    fns[0] = 6'd33; fns[1] = 6'd35; fns[2] = 6'd36; fns[3] = 6'd37;
    fns[4] = 6'd42; fns[5] = 6'd43; fns[6] = 6'd0;

    bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #7;
    w = '0;
    check("reset_state", sample(), w);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;

    gen(6'b000000, 6'd33, 1'b0, 0, 0);
    gen(6'b100011, 6'd0, 1'b0, 0, 3);
    gen(6'b000100, 6'd0, 1'b1, 0, 0);
    gen(6'b000100, 6'd0, 1'b0, 0, 0);
    gen(6'b101011, 6'd0, 1'b0, 1, 2);
    gen(6'b000010, 6'd0, 1'b0, 0, 0);
    gen(6'b111111, 6'd0, 1'b0, 0, 0);
    gen(6'b000000, 6'd0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) gen(6'b001001, 6'd0, 1'b0, 0, 0);
    gen(6'b001101, 6'd0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      gen(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(posedge clk);
    go = 1'b1;
    n = 0;
    while ((plan.size() > 0 || exp_q.size() > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout got=%0d want=<5000", n);
    end
    @(posedge clk);
    go = 1'b0;

    // Reset in the middle of a stalled lw memory phase.
    #1; bus.op = 6'b100011; bus.func = '0; bus.mem_ready = 1'b1;
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    w = '0; w.st = 3'd3; w.memrd = 1'b1; w.ill = ill_m; w.cnt = cnt_m;
    check("lw_mem_stall", sample(), w);
    #2 rst = 1'b1;
    #1;
    w = '0;
    check("async_reset", sample(), w);
    @(posedge clk); #1;
    check("reset_hold", sample(), w);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
